// File: rtl/instr_fetch.sv
// RV32 instruction fetch stage: PC, credit-limited imem requests,
// response FIFO toward decode, redirect flush with stale-response discard.
module instr_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    fq_entry_t     fq [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_nx;
    logic [CW-1:0] discard;
    logic [CW:0]   used;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   tgt;
    logic          acc;
    logic          rsp;
    logic          push;
    logic          pop;

    // Buffered plus outstanding words never exceed the FIFO size.
    assign used           = {1'b0, count} + {1'b0, inflight};
    assign imem_req_valid = rst_n && (used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign acc  = imem_req_valid && imem_req_ready;
    assign rsp  = imem_rsp_valid && (inflight != '0);
    assign push = rsp && (discard == '0) && !redirect_valid;
    assign pop  = out_valid && out_ready && !redirect_valid;

    assign inflight_nx = inflight + CW'(acc) - CW'(rsp);
    assign tgt         = redirect_pc & 32'hFFFF_FFFC;

    assign out_valid = (count != '0);
    assign out_pc    = fq[rptr].pc;
    assign out_instr = fq[rptr].instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
            count    <= '0;
            wptr     <= '0;
            rptr     <= '0;
        end else begin
            inflight <= inflight_nx;
            if (redirect_valid) begin
                fetch_pc <= tgt;
                rsp_pc   <= tgt;
                discard  <= inflight_nx;
                wptr     <= '0;
                rptr     <= '0;
            end else begin
                if (acc)
                    fetch_pc <= fetch_pc + 32'd4;
                if (rsp && (discard != '0))
                    discard <= discard - CW'(1);
                if (push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                    wptr   <= wptr + AW'(1);
                end
                if (pop)
                    rptr <= rptr + AW'(1);
            end
            unique case (1'b1)
                redirect_valid: count <= '0;
                push && !pop:   count <= count + CW'(1);
                pop && !push:   count <= count - CW'(1);
                default:        ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                fq[i] <= '0;
        end else if (push) begin
            fq[wptr] <= '{pc: rsp_pc, instr: imem_rsp_data};
        end
    end

endmodule
